// File: rtl/io_mailbox_if.sv
// Bundle between the CPU-facing I/O ports and the host byte streams of io_mailbox.
// master = CPU/host side, slave = mailbox.
interface io_mailbox_if;
  logic [15:0] io64_out;
  logic [15:0] io65_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output io64_out, tx_ready, rx_data, rx_valid,
    input  io65_in, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  io64_out, tx_ready, rx_data, rx_valid,
    output io65_in, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_mailbox.sv
// Toggle REQ/ACK command mailbox between CPU I/O ports and two byte FIFOs.
//   state | meaning
//   IDLE  | wait for a stable REQ toggle on the double-sampled command word
//   EXEC  | perform the latched command for one cycle and return ACK
module io_mailbox #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         reset,
  io_mailbox_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [1:0]  CMD_NOP   = 2'b00;
  localparam logic [1:0]  CMD_PUSH  = 2'b01;
  localparam logic [1:0]  CMD_POP   = 2'b10;
  localparam logic [1:0]  CMD_CLEAR = 2'b11;
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);

  state_t state, state_nxt;

  logic [15:0] s1, s2;
  logic        req_q;
  logic [1:0]  cmd_q;
  logic [7:0]  wdata_q;
  logic        ack, err;
  logic [7:0]  rdata;

  logic [7:0]  tx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0] tx_cnt;
  logic [7:0]  rx_mem [DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0] rx_cnt;

  logic accept, do_push, do_pop, do_clear;
  logic tx_full, tx_push, tx_pop;
  logic rx_empty, rx_push, rx_pop;
  logic [3:0] rx_cnt_sat;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (s2[15] != ack && s2 == s1) state_nxt = EXEC;
      EXEC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_clear = 1'b0;
    if (state == IDLE) begin
      accept = (state_nxt == EXEC);
    end else begin
      case (cmd_q)
        CMD_PUSH:  do_push  = 1'b1;
        CMD_POP:   do_pop   = 1'b1;
        CMD_CLEAR: do_clear = 1'b1;
        default:   ;
      endcase
    end
  end

  assign tx_full  = (tx_cnt == CNT_FULL);
  assign tx_push  = do_push & ~tx_full;
  assign tx_pop   = bus.tx_valid & bus.tx_ready;
  assign rx_empty = (rx_cnt == '0);
  assign rx_push  = bus.rx_valid & bus.rx_ready & ~do_clear;
  assign rx_pop   = do_pop & ~rx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      req_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      wdata_q <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      tx_wr   <= '0;
      tx_rd   <= '0;
      tx_cnt  <= '0;
      rx_wr   <= '0;
      rx_rd   <= '0;
      rx_cnt  <= '0;
    end else begin
      s1 <= bus.io64_out;
      s2 <= s1;
      if (accept) begin
        req_q   <= s2[15];
        cmd_q   <= s2[14:13];
        wdata_q <= s2[7:0];
      end
      if (state == EXEC) ack <= req_q;

      // CLEAR wins over any host handshake landing in the same cycle
      if (do_clear) begin
        tx_wr  <= '0;
        tx_rd  <= '0;
        tx_cnt <= '0;
        rx_wr  <= '0;
        rx_rd  <= '0;
        rx_cnt <= '0;
        err    <= 1'b0;
        rdata  <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + 1'b1;
        if (tx_pop)  tx_rd <= tx_rd + 1'b1;
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + 1'b1;
          2'b01:   tx_cnt <= tx_cnt - 1'b1;
          default: ;
        endcase
        if (do_push && tx_full) err <= 1'b1;

        if (rx_push) rx_wr <= rx_wr + 1'b1;
        if (rx_pop)  rx_rd <= rx_rd + 1'b1;
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + 1'b1;
          2'b01:   rx_cnt <= rx_cnt - 1'b1;
          default: ;
        endcase
        if (do_pop) begin
          if (rx_empty) begin
            rdata <= '0;
            err   <= 1'b1;
          end else begin
            rdata <= rx_mem[rx_rd];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= wdata_q;
    if (rx_push) rx_mem[rx_wr] <= bus.rx_data;
  end

  always_comb begin
    if (32'(rx_cnt) > 32'd15) rx_cnt_sat = 4'hF;
    else                      rx_cnt_sat = 4'(rx_cnt);
  end

  assign bus.io65_in  = {ack, ~rx_empty, tx_full, err, rx_cnt_sat, rdata};
  assign bus.tx_valid = (tx_cnt != '0);
  assign bus.tx_data  = tx_mem[tx_rd];
  assign bus.rx_ready = (rx_cnt != CNT_FULL);

endmodule

// File: tb/tb_io_mailbox.sv
// Bench for io_mailbox: queue-based reference model compared every cycle,
// directed literal scenarios, then randomized firmware/host traffic.
module tb_io_mailbox;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_mailbox_if bus();

  io_mailbox #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic cur_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queues plus a two-deep sample history and a pending command.
  logic [7:0]  mtx[$];
  logic [7:0]  mrx[$];
  logic        m_ack = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_req = 1'b0;
  logic [7:0]  m_rdata = '0, m_wdata = '0;
  logic [1:0]  m_cmd = '0;
  logic [15:0] m_s1 = '0, m_s2 = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    int  txn, rxn;
    bit  hpop, hwr;
    if (reset) begin
      mtx.delete(); mrx.delete();
      m_ack = 0; m_err = 0; m_busy = 0; m_rdata = 0;
      m_s1 = 0; m_s2 = 0;
      m_valid = 1'b1;
    end else begin
      txn  = mtx.size();
      rxn  = mrx.size();
      hpop = (txn != 0) && bus.tx_ready;
      hwr  = bus.rx_valid && (rxn != DEPTH);
      if (m_busy && m_cmd == 2'd3) begin
        mtx.delete(); mrx.delete();
        m_err = 0; m_rdata = 0;
      end else begin
        if (hpop) void'(mtx.pop_front());
        if (m_busy && m_cmd == 2'd1) begin
          if (txn == DEPTH) m_err = 1;
          else mtx.push_back(m_wdata);
        end
        if (m_busy && m_cmd == 2'd2) begin
          if (rxn != 0) m_rdata = mrx.pop_front();
          else begin m_rdata = 0; m_err = 1; end
        end
        if (hwr) mrx.push_back(bus.rx_data);
      end
      if (m_busy) begin
        m_ack  = m_req;
        m_busy = 0;
      end else if (m_s2[15] != m_ack && m_s2 == m_s1) begin
        m_busy  = 1;
        m_req   = m_s2[15];
        m_cmd   = m_s2[14:13];
        m_wdata = m_s2[7:0];
      end
      m_s2 = m_s1;
      m_s1 = bus.io64_out;
    end
  end

  function automatic logic [15:0] exp_io65();
    int n = mrx.size();
    logic [3:0] sat = (n > 15) ? 4'hF : 4'(n);
    return {m_ack, mrx.size() != 0, mtx.size() == DEPTH, m_err, sat, m_rdata};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("io65_in", 32'(bus.io65_in), 32'(exp_io65()));
      check("tx_valid", 32'(bus.tx_valid), 32'(mtx.size() != 0));
      if (mtx.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(mtx[0]));
      check("rx_ready", 32'(bus.rx_ready), 32'(mrx.size() != DEPTH));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.io64_out = '0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    cur_req      = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] data);
    cur_req      = ~cur_req;
    bus.io64_out = {cur_req, cmd, 5'b0, data};
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.io65_in[15] == cur_req) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL ack_timeout: ack %b never reached req %b", bus.io65_in[15], cur_req);
  endtask

  initial begin
    bus.io64_out = '0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    do_reset();

    repeat (4) tick();
    check("reset_io65", 32'(bus.io65_in), 32'h0000);
    check("reset_txv", 32'(bus.tx_valid), 32'h0);
    check("reset_rxr", 32'(bus.rx_ready), 32'h1);

    // one-cycle REQ glitch must not be accepted
    bus.io64_out = 16'hA0A5;
    tick();
    bus.io64_out = 16'h0000;
    repeat (6) tick();
    check("glitch_io65", 32'(bus.io65_in), 32'h0000);
    check("glitch_txv", 32'(bus.tx_valid), 32'h0);

    // PUSH A5 with edge-accurate ACK latency
    cur_req      = 1'b1;
    bus.io64_out = 16'hA0A5;
    repeat (3) tick();
    check("ack_edge2", 32'(bus.io65_in[15]), 32'h0);
    tick();
    check("ack_edge3", 32'(bus.io65_in[15]), 32'h1);
    check("push_txv", 32'(bus.tx_valid), 32'h1);
    check("push_txd", 32'(bus.tx_data), 32'hA5);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("host_pop_txv", 32'(bus.tx_valid), 32'h0);

    // host byte in, then POP
    do_reset();
    bus.rx_data  = 8'h3C;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check("rx_in_io65", 32'(bus.io65_in), 32'h4100);
    send_cmd(2'b10, 8'h00);
    check("pop_io65", 32'(bus.io65_in), 32'h803C);

    // fill TX to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_cmd(2'b01, 8'(i));
    check("full_flag", 32'(bus.io65_in[13]), 32'h1);
    check("full_noerr", 32'(bus.io65_in[12]), 32'h0);
    send_cmd(2'b01, 8'hFF);
    check("ovf_err", 32'(bus.io65_in[12]), 32'h1);
    check("ovf_ack", 32'(bus.io65_in[15]), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_txv", 32'(bus.tx_valid), 32'h1);
      check("drain_txd", 32'(bus.tx_data), 32'(i));
      bus.tx_ready = 1'b1;
      tick();
    end
    bus.tx_ready = 1'b0;
    check("drained_txv", 32'(bus.tx_valid), 32'h0);

    // POP empty, CLEAR, CLEAR racing host RX writes
    do_reset();
    send_cmd(2'b10, 8'h00);
    check("pop_empty_rdata", 32'(bus.io65_in[7:0]), 32'h00);
    check("pop_empty_err", 32'(bus.io65_in[12]), 32'h1);
    send_cmd(2'b11, 8'h00);
    check("clear_err", 32'(bus.io65_in[12]), 32'h0);
    bus.rx_data  = 8'h77;
    bus.rx_valid = 1'b1;
    send_cmd(2'b11, 8'h00);
    bus.rx_valid = 1'b0;
    check("clear_rx_cnt", 32'(bus.io65_in[11:8]), 32'h0);
    check("clear_rx_ne", 32'(bus.io65_in[14]), 32'h0);

    // randomized traffic with one mid-run reset
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = 8'($urandom);
      if (c == 600) reset = 1'b1;
      else          reset = 1'b0;
      if (bus.io65_in[15] == cur_req && $urandom_range(0, 3) == 0) begin
        logic [1:0] cmd;
        cmd = 2'($urandom_range(0, 3));
        if (cmd == 2'b11 && $urandom_range(0, 3) != 0) cmd = 2'b01;
        cur_req      = ~cur_req;
        bus.io64_out = {cur_req, cmd, 5'($urandom), 8'($urandom)};
      end
      tick();
    end
    reset        = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
